mem_port_arbiter: RTL

//  Shares the single-port 32-bit instruction/data memory between two requesters.
//  - Fetch port: read-only, driven by PC sequencing.
//  - Data port: lw/sw traffic.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_fetch_buf.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and owner encodings plus default widths.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_fetch_buf.sv
// One-entry fetch buffer: {tag, data, valid} with hit, fill, invalidate.
// Only instantiated when MEM_ARB_FETCH_BUF_EN is defined.
module mem_arb_fetch_buf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              fill_en_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inv_en_i,
  input  logic [ADDR_W-1:0] inv_addr_i
);

  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  assign hit_o  = valid_q && (tag_q == lookup_addr_i);
  assign data_o = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (fill_en_i) begin
        tag_q   <= fill_addr_i;
        data_q  <= fill_data_i;
        valid_q <= 1'b1;
      end
      // a store to the cached word makes the copy stale
      if (inv_en_i && valid_q && (inv_addr_i == tag_q))
        valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port priority, fetch anti-starvation streak.
// Optional one-entry fetch buffer under MEM_ARB_FETCH_BUF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

  state_e            state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              idle;
  logic              fetch_turn;
  logic              fetch_acc;
  logic              fb_hit;
  logic [DATA_W-1:0] fb_data;

  assign idle = (state_q == IDLE) && !reset;

`ifdef MEM_ARB_FETCH_BUF_EN
  mem_arb_fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fbuf (
    .clk          (clk),
    .reset        (reset),
    .lookup_addr_i(if_addr),
    .hit_o        (fb_hit),
    .data_o       (fb_data),
    .fill_en_i    ((state_q == ACCESS) && (owner_q == OWN_FETCH)),
    .fill_addr_i  (addr_q),
    .fill_data_i  (mem_rdata),
    .inv_en_i     (d_gnt && d_we),
    .inv_addr_i   (d_addr)
  );
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif

  // fetch wins a contested slot only once the data streak is exhausted
  assign fetch_turn = if_req && d_req && (streak_q == SMAX);

  always_comb begin
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (idle) begin
      if (if_req && fb_hit) begin
        if_gnt = 1'b1;
        d_gnt  = d_req;
      end else begin
        d_gnt  = d_req && !fetch_turn;
        if_gnt = if_req && (!d_req || fetch_turn);
      end
    end
  end

  assign fetch_acc = if_gnt && !fb_hit;

  always_comb begin
    streak_d = streak_q;
    if (fetch_acc)
      streak_d = '0;
    else if (d_gnt && if_req && !fb_hit)
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      streak_q    <= streak_d;
      unique case (state_q)
        IDLE: begin
          if (d_gnt || fetch_acc) begin
            state_q <= ACCESS;
            owner_q <= d_gnt ? OWN_DATA : OWN_FETCH;
            addr_q  <= d_gnt ? d_addr : if_addr;
            we_q    <= d_gnt && d_we;
            wdata_q <= (d_gnt && d_we) ? d_wdata : '0;
          end
          if (if_gnt && fb_hit) begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= fb_data;
          end
        end
        ACCESS: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          wdata_q <= '0;
          if (owner_q == OWN_DATA) begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ACCESS);

endmodule
